// File: rtl/ascensor_ctrl.sv
// Elevator sequencing FSM that steps a 4-bit floor counter and times travel and door intervals.
// Defining ASCENSOR_EMERGENCIA_EN adds the emergencia input (forced descent to floor 0, door held open).
module ascensor_ctrl #(
    parameter int unsigned N_PISOS  = 8,
    parameter int unsigned T_VIAJE  = 4,
    parameter int unsigned T_PUERTA = 6
) (
    input  logic               clk,
    input  logic               rst,
`ifdef ASCENSOR_EMERGENCIA_EN
    input  logic               emergencia,
`endif
    input  logic [N_PISOS-1:0] llamada,
    input  logic [3:0]         piso_actual,
    output logic               cnt_enb,
    output logic               cnt_subir,
    output logic               puerta_abierta,
    output logic [N_PISOS-1:0] pendientes,
    output logic [1:0]         estado
);

    localparam int unsigned T_MAX = (T_VIAJE > T_PUERTA) ? T_VIAJE : T_PUERTA;
    localparam int unsigned TW    = $clog2(T_MAX + 1);
    localparam logic [TW-1:0] FIN_VIAJE  = TW'(T_VIAJE - 1);
    localparam logic [TW-1:0] FIN_PUERTA = TW'(T_PUERTA - 1);

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        MOVIENDO = 2'd1,
        LLEGADA  = 2'd2,
        PUERTA   = 2'd3
    } estado_t;

    estado_t            state, state_next;
    logic [TW-1:0]      timer, timer_next;
    logic               dir, dir_next;
    logic [N_PISOS-1:0] pend_next;
    logic               cnt_enb_next, puerta_next;

    logic [N_PISOS-1:0] m_aqui, m_arriba, m_abajo;
    logic               piso_valido, puede_subir, puede_bajar;
    logic               aqui, arriba, abajo, llamada_aqui, sigue, opuesto;
    logic               emerg;

    // Floor masks relative to the counter's current value; all-zero when the floor is out of range
    always_comb begin
        m_aqui   = '0;
        m_arriba = '0;
        m_abajo  = '0;
        for (int i = 0; i < int'(N_PISOS); i++) begin
            m_aqui[i]   = (piso_actual == 4'(i));
            m_arriba[i] = (piso_actual < 4'(i));
            m_abajo[i]  = (piso_actual > 4'(i)) && piso_valido;
        end
    end

    assign piso_valido  = ({1'b0, piso_actual} < 5'(N_PISOS));
    assign puede_subir  = ({1'b0, piso_actual} < 5'(N_PISOS - 1));
    assign puede_bajar  = piso_valido && (piso_actual != 4'd0);
    assign aqui         = |(pendientes & m_aqui);
    assign arriba       = |(pendientes & m_arriba);
    assign abajo        = |(pendientes & m_abajo);
    assign llamada_aqui = |(llamada & m_aqui);
    assign sigue        = dir ? arriba : abajo;
    assign opuesto      = dir ? abajo : arriba;
    assign estado       = state;

`ifdef ASCENSOR_EMERGENCIA_EN
    logic emerg_prev;
    assign emerg = emergencia;
`else
    assign emerg = 1'b0;
`endif

    // State register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= REPOSO;
            timer          <= '0;
            dir            <= 1'b1;
            pendientes     <= '0;
            cnt_enb        <= 1'b0;
            cnt_subir      <= 1'b1;
            puerta_abierta <= 1'b0;
`ifdef ASCENSOR_EMERGENCIA_EN
            emerg_prev     <= 1'b0;
`endif
        end else begin
            state          <= state_next;
            timer          <= timer_next;
            dir            <= dir_next;
            pendientes     <= pend_next;
            cnt_enb        <= cnt_enb_next;
            cnt_subir      <= dir_next;
            puerta_abierta <= puerta_next;
`ifdef ASCENSOR_EMERGENCIA_EN
            emerg_prev     <= emerg;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        timer_next = timer;
        dir_next   = dir;
        case (state)
            REPOSO: begin
                if (aqui) begin
                    state_next = PUERTA;
                    timer_next = '0;
                end else if (arriba) begin
                    state_next = MOVIENDO;
                    dir_next   = 1'b1;
                    timer_next = '0;
                end else if (abajo) begin
                    state_next = MOVIENDO;
                    dir_next   = 1'b0;
                    timer_next = '0;
                end
            end
            MOVIENDO: begin
                if (timer == FIN_VIAJE) begin
                    state_next = LLEGADA;
                    timer_next = '0;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            LLEGADA: begin
                timer_next = '0;
                if (aqui) begin
                    state_next = PUERTA;
                end else if (sigue) begin
                    state_next = MOVIENDO;
                end else if (opuesto) begin
                    state_next = MOVIENDO;
                    dir_next   = ~dir;
                end else begin
                    state_next = REPOSO;
                end
            end
            PUERTA: begin
                if (llamada_aqui) begin
                    timer_next = '0;
                end else if (timer == FIN_PUERTA) begin
                    timer_next = '0;
                    if (sigue) begin
                        state_next = MOVIENDO;
                    end else if (opuesto) begin
                        state_next = MOVIENDO;
                        dir_next   = ~dir;
                    end else begin
                        state_next = REPOSO;
                    end
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            default: begin
                state_next = REPOSO;
                timer_next = '0;
            end
        endcase

        // Emergency: a step in progress finishes, otherwise head down or hold the door at floor 0
        if (emerg && state != MOVIENDO) begin
            timer_next = '0;
            if (piso_actual == 4'd0) begin
                state_next = PUERTA;
            end else begin
                state_next = MOVIENDO;
                dir_next   = 1'b0;
            end
        end
`ifdef ASCENSOR_EMERGENCIA_EN
        else if (!emerg && emerg_prev && state == PUERTA) begin
            state_next = REPOSO;
            timer_next = '0;
        end
`endif

        if (state_next == MOVIENDO && ((dir_next && !puede_subir) || (!dir_next && !puede_bajar))) begin
            state_next = REPOSO;
            timer_next = '0;
        end
        if (!piso_valido) begin
            state_next = REPOSO;
            timer_next = '0;
        end
    end

    // Output and request-latch logic
    always_comb begin
        pend_next = pendientes | llamada;
        if (state == PUERTA) begin
            pend_next = (pendientes | llamada) & ~m_aqui;
        end
        if (emerg) begin
            pend_next = '0;
        end
        cnt_enb_next = (state_next == MOVIENDO) && (timer_next == FIN_VIAJE);
        puerta_next  = (state_next == PUERTA);
    end

endmodule
